reg_op_sequencer: RTL and testbench
===================================

Name: reg_op_sequencer

Overview:
- Command-driven micro-sequencer sitting directly upstream of the 64 x 16 register file.
- Drives the register file's AddressA/AddressB/WriteData/WriteEnable ports and consumes its combinational ReadDataA/ReadDataB.
- Per command: fetches two operands, executes one ALU op, and writes the result back to the destination register (write port shares AddressA).
- Game logic (paddle/ball update) issues commands through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, register and datapath width.
- ADDR_WIDTH, 6, register address width (64 registers).

Ports:
- Clock  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- CmdValid  input  1  command present
- CmdReady  output  1  sequencer can accept a command
- CmdOp  input  3  operation code
- CmdDest  input  ADDR_WIDTH  destination / operand-A register
- CmdSrcB  input  ADDR_WIDTH  operand-B register
- CmdImm  input  DATA_WIDTH  immediate for LOADI
- RegAddressA  output  ADDR_WIDTH  to register file AddressA
- RegAddressB  output  ADDR_WIDTH  to register file AddressB
- RegWriteData  output  DATA_WIDTH  to register file WriteData
- RegWriteEnable  output  1  to register file WriteEnable
- RegReadDataA  input  DATA_WIDTH  from register file ReadDataA
- RegReadDataB  input  DATA_WIDTH  from register file ReadDataB
- Result  output  DATA_WIDTH  last computed result, held until next EXEC
- Done  output  1  one-cycle pulse at completion of each command
- Busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state = IDLE.
  - CmdReady = 1, Busy = 0, Done = 0, RegWriteEnable = 0.
  - RegAddressA = 0, RegAddressB = 0, RegWriteData = 0, Result = 0.
  - All latched command fields are cleared.
- FSM states: IDLE -> FETCH -> EXEC -> WRITE -> IDLE. No other transitions except Reset.
- IDLE:
  - CmdReady = 1.
  - On CmdValid && CmdReady, latch CmdOp/CmdDest/CmdSrcB/CmdImm and go to FETCH.
  - CmdValid while not IDLE is ignored; CmdReady = 0 in those states.
- FETCH (1 cycle):
  - RegAddressA = latched Dest, RegAddressB = latched SrcB.
  - OpA/OpB registers capture RegReadDataA/RegReadDataB at the end of the cycle.
- EXEC (1 cycle): Result <= f(OpA, OpB, Imm), with arithmetic modulo 2^DATA_WIDTH:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOVB: B
  - 6 LOADI: Imm
  - 7 CMP: A-B, result produced but not written back
- WRITE (1 cycle):
  - RegAddressA = Dest, RegWriteData = Result.
  - RegWriteEnable = 1 except for CMP, where it stays 0.
  - Done = 1. Next state IDLE.
- Outside WRITE, RegWriteEnable = 0 always.
- Outside FETCH and WRITE, address outputs = 0.
- Latency: accept edge to Done = 3 cycles. Register updated at the end of the WRITE cycle.
- Throughput: 1 command per 4 cycles. The next command is acceptable in the IDLE cycle after WRITE.
- Read-after-write: a command following a write to the same register sees the new value, because FETCH is always at least 2 cycles after the write edge.
- Dest == SrcB is legal; both operands read the same register.
- Reset mid-operation: the FSM returns to IDLE on the reset edge. RegWriteEnable is 0 from that cycle, so no partial write occurs and the in-flight command is dropped with no Done.

Optional Feature:
- Macro: SEQ_FLAGS_EN.
- When defined, adds output ports Zero, Carry and Negative (1 bit each), registered in EXEC alongside Result:
  - Zero = (Result == 0).
  - Negative = Result MSB.
  - Carry = carry-out of ADD, or borrow (A<B unsigned) for SUB/CMP; 0 for other ops.
  - All flags reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles -> CmdReady=1, Busy=0, RegWriteEnable never asserted, all outputs 0.
- Preload R3=0x0005, R4=0x0003; ADD Dest=3 SrcB=4 -> Done 3 cycles after accept, R3=0x0008, Result=0x0008.
- Wrap-around:
  - R1=0xFFFF, R2=0x0001; ADD Dest=1 SrcB=2 -> R1=0x0000; with SEQ_FLAGS_EN, Zero=1, Carry=1.
  - SUB 0x0000-0x0001 -> 0xFFFF, Negative=1.
- CMP Dest=5 SrcB=6 (R5=R6=0x1234) -> Done pulses, RegWriteEnable stays 0, R5 unchanged, Result=0x0000.
- LOADI Dest=63 Imm=0xABCD immediately followed by MOVB Dest=0 SrcB=63 (CmdValid held high) -> second accepted only in the IDLE cycle after the first Done; R0=0xABCD.
- Assert Reset during EXEC of ADD Dest=7 -> R7 unchanged, no Done, CmdReady=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// Command-driven micro-sequencer for a 64 x 16 register file: FETCH -> EXEC -> WRITE.
// Optional status flags (Zero/Carry/Negative) enabled by defining SEQ_FLAGS_EN.
module reg_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic [2:0]            CmdOp,
  input  logic [ADDR_WIDTH-1:0] CmdDest,
  input  logic [ADDR_WIDTH-1:0] CmdSrcB,
  input  logic [DATA_WIDTH-1:0] CmdImm,
  output logic [ADDR_WIDTH-1:0] RegAddressA,
  output logic [ADDR_WIDTH-1:0] RegAddressB,
  output logic [DATA_WIDTH-1:0] RegWriteData,
  output logic                  RegWriteEnable,
  input  logic [DATA_WIDTH-1:0] RegReadDataA,
  input  logic [DATA_WIDTH-1:0] RegReadDataB,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Done,
  output logic                  Busy
`ifdef SEQ_FLAGS_EN
  ,
  output logic                  Zero,
  output logic                  Carry,
  output logic                  Negative
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WRITE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_MOVB  = 3'd5,
    OP_LOADI = 3'd6,
    OP_CMP   = 3'd7
  } op_e;

  state_e                state, state_next;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [ADDR_WIDTH-1:0] srcb_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] alu_result;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (CmdValid) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    CmdReady       = 1'b0;
    Busy           = 1'b1;
    Done           = 1'b0;
    RegAddressA    = '0;
    RegAddressB    = '0;
    RegWriteData   = '0;
    RegWriteEnable = 1'b0;
    case (state)
      S_IDLE: begin
        CmdReady = 1'b1;
        Busy     = 1'b0;
      end
      S_FETCH: begin
        RegAddressA = dest_q;
        RegAddressB = srcb_q;
      end
      S_WRITE: begin
        RegAddressA    = dest_q;
        RegWriteData   = result_q;
        RegWriteEnable = (op_q != OP_CMP);
        Done           = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_MOVB:  alu_result = op_b;
      OP_LOADI: alu_result = imm_q;
      OP_CMP:   alu_result = op_a - op_b;
      default:  alu_result = '0;
    endcase
  end

  // Command latch, operand capture and result register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q     <= OP_ADD;
      dest_q   <= '0;
      srcb_q   <= '0;
      imm_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CmdValid) begin
            op_q   <= op_e'(CmdOp);
            dest_q <= CmdDest;
            srcb_q <= CmdSrcB;
            imm_q  <= CmdImm;
          end
        end
        S_FETCH: begin
          op_a <= RegReadDataA;
          op_b <= RegReadDataB;
        end
        S_EXEC:  result_q <= alu_result;
        default: ;
      endcase
    end
  end

  assign Result = result_q;

`ifdef SEQ_FLAGS_EN
  logic [DATA_WIDTH:0] sum_ext;
  logic                alu_carry;
  logic                zero_q, carry_q, negative_q;

  // Carry is the ADD carry-out; for SUB/CMP it reports an unsigned borrow.
  always_comb begin
    sum_ext   = {1'b0, op_a} + {1'b0, op_b};
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD:         alu_carry = sum_ext[DATA_WIDTH];
      OP_SUB, OP_CMP: alu_carry = (op_a < op_b);
      default:        alu_carry = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
    end else if (state == S_EXEC) begin
      zero_q     <= (alu_result == '0);
      carry_q    <= alu_carry;
      negative_q <= alu_result[DATA_WIDTH-1];
    end
  end

  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign Negative = negative_q;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: behavioural register file plus a reference model of the
// command set; directed scenarios followed by random commands.
module tb_reg_op_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdOp = '0;
  logic [5:0]  CmdDest = '0;
  logic [5:0]  CmdSrcB = '0;
  logic [15:0] CmdImm = '0;
  logic [5:0]  RegAddressA, RegAddressB;
  logic [15:0] RegWriteData;
  logic        RegWriteEnable;
  logic [15:0] RegReadDataA, RegReadDataB;
  logic [15:0] Result;
  logic        Done, Busy;
`ifdef SEQ_FLAGS_EN
  logic        Zero, Carry, Negative;
`endif

  int unsigned total = 0;
  int unsigned passed = 0;

  // Register file attached to the DUT, and the bench's expected image of it
  logic [15:0] rf  [64] = '{default: '0};
  logic [15:0] mrf [64] = '{default: '0};

  // Expected values of the status outputs after the most recent completed command
  logic [15:0] exp_result = '0;
  logic        exp_zero = 1'b0, exp_carry = 1'b0, exp_neg = 1'b0;

  reg_op_sequencer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(6)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .CmdValid      (CmdValid),
    .CmdReady      (CmdReady),
    .CmdOp         (CmdOp),
    .CmdDest       (CmdDest),
    .CmdSrcB       (CmdSrcB),
    .CmdImm        (CmdImm),
    .RegAddressA   (RegAddressA),
    .RegAddressB   (RegAddressB),
    .RegWriteData  (RegWriteData),
    .RegWriteEnable(RegWriteEnable),
    .RegReadDataA  (RegReadDataA),
    .RegReadDataB  (RegReadDataB),
    .Result        (Result),
    .Done          (Done),
    .Busy          (Busy)
`ifdef SEQ_FLAGS_EN
    ,
    .Zero          (Zero),
    .Carry         (Carry),
    .Negative      (Negative)
`endif
  );

  always #5 Clock = ~Clock;

  assign RegReadDataA = rf[RegAddressA];
  assign RegReadDataB = rf[RegAddressB];
  always @(posedge Clock) if (RegWriteEnable) rf[RegAddressA] <= RegWriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference behaviour of one command; arithmetic done wide, then reduced mod 2^16
  task automatic model_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] imm);
    int unsigned wide;
    exp_carry = 1'b0;
    case (op)
      3'd0: begin wide = a + b; exp_carry = (wide > 32'hFFFF); end
      3'd1: begin wide = 32'h10000 + a - b; exp_carry = (a < b); end
      3'd2: wide = a & b;
      3'd3: wide = a | b;
      3'd4: wide = a ^ b;
      3'd5: wide = b;
      3'd6: wide = imm;
      default: begin wide = 32'h10000 + a - b; exp_carry = (a < b); end
    endcase
    exp_result = wide[15:0];
    exp_zero   = (exp_result == 16'h0000);
    exp_neg    = exp_result[15];
  endtask

  task automatic check_flags(input string tag);
`ifdef SEQ_FLAGS_EN
    check({tag, "_zero"},  Zero,     exp_zero);
    check({tag, "_carry"}, Carry,    exp_carry);
    check({tag, "_neg"},   Negative, exp_neg);
`else
    if (tag.len() == 0) $display("empty flag tag");
`endif
  endtask

  // Issue one command and follow it through to completion, checking every stage
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [5:0] dest,
                         input logic [5:0] srcb, input logic [15:0] imm);
    int unsigned cyc;
    model_cmd(op, mrf[dest], mrf[srcb], imm);
    @(negedge Clock);
    check({tag, "_ready"}, CmdReady, 1'b1);
    CmdValid = 1'b1; CmdOp = op; CmdDest = dest; CmdSrcB = srcb; CmdImm = imm;
    @(negedge Clock);
    CmdValid = 1'b0;
    CmdOp = 3'($urandom); CmdDest = 6'($urandom); CmdSrcB = 6'($urandom); CmdImm = 16'($urandom);
    check({tag, "_fetch_a"}, RegAddressA, dest);
    check({tag, "_fetch_b"}, RegAddressB, srcb);
    check({tag, "_busy"}, {Busy, CmdReady}, 2'b10);
    cyc = 1;
    while (Done !== 1'b1 && cyc < 8) begin
      check({tag, "_no_we_early"}, RegWriteEnable, 1'b0);
      @(negedge Clock);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_we"}, RegWriteEnable, (op != 3'd7));
    check({tag, "_waddr"}, RegAddressA, dest);
    check({tag, "_wdata"}, RegWriteData, exp_result);
    check({tag, "_result"}, Result, exp_result);
    check_flags(tag);
    if (op != 3'd7) mrf[dest] = exp_result;
    @(negedge Clock);
    check({tag, "_done_pulse"}, Done, 1'b0);
    check({tag, "_idle_ready"}, CmdReady, 1'b1);
    check({tag, "_rf"}, rf[dest], mrf[dest]);
    check({tag, "_result_hold"}, Result, exp_result);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("idle_ready", CmdReady, 1'b1);
      check("idle_busy", Busy, 1'b0);
      check("idle_done", Done, 1'b0);
      check("idle_we", RegWriteEnable, 1'b0);
      check("idle_addr", {RegAddressA, RegAddressB}, '0);
      check("idle_wdata", RegWriteData, 16'h0000);
      check("idle_result", Result, 16'h0000);
      check_flags("idle");
    end

    // Basic ADD
    run_cmd("pre_r3", 3'd6, 6'd3, 6'd0, 16'h0005);
    run_cmd("pre_r4", 3'd6, 6'd4, 6'd0, 16'h0003);
    run_cmd("add34", 3'd0, 6'd3, 6'd4, 16'h0000);
    check("add34_value", rf[3], 16'h0008);

    // Wrap-around and borrow
    run_cmd("pre_r1", 3'd6, 6'd1, 6'd0, 16'hFFFF);
    run_cmd("pre_r2", 3'd6, 6'd2, 6'd0, 16'h0001);
    run_cmd("add_wrap", 3'd0, 6'd1, 6'd2, 16'h0000);
    check("add_wrap_value", rf[1], 16'h0000);
    run_cmd("sub_wrap", 3'd1, 6'd1, 6'd2, 16'h0000);
    check("sub_wrap_value", rf[1], 16'hFFFF);

    // CMP leaves the destination alone
    run_cmd("pre_r5", 3'd6, 6'd5, 6'd0, 16'h1234);
    run_cmd("pre_r6", 3'd6, 6'd6, 6'd0, 16'h1234);
    run_cmd("cmp56", 3'd7, 6'd5, 6'd6, 16'h0000);
    check("cmp56_r5", rf[5], 16'h1234);
    check("cmp56_result", Result, 16'h0000);

    // Back-to-back with CmdValid held: second command waits for IDLE
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = 3'd6; CmdDest = 6'd63; CmdSrcB = 6'd0; CmdImm = 16'hABCD;
    @(negedge Clock);
    CmdOp = 3'd5; CmdDest = 6'd0; CmdSrcB = 6'd63; CmdImm = 16'h0000;
    for (int c = 1; c <= 3; c++) begin
      check("held_not_ready", CmdReady, 1'b0);
      check("held_done", Done, (c == 3));
      if (c < 3) @(negedge Clock);
    end
    mrf[63] = 16'hABCD;
    @(negedge Clock);
    check("held_idle_ready", CmdReady, 1'b1);
    check("held_idle_busy", Busy, 1'b0);
    check("held_r63", rf[63], 16'hABCD);
    @(negedge Clock);
    CmdValid = 1'b0;
    check("held_second_accepted", Busy, 1'b1);
    check("held_second_fetch_b", RegAddressB, 6'd63);
    repeat (2) @(negedge Clock);
    check("held_second_done", Done, 1'b1);
    check("held_second_wdata", RegWriteData, 16'hABCD);
    mrf[0] = 16'hABCD;
    exp_result = 16'hABCD;
    @(negedge Clock);
    check("held_r0", rf[0], 16'hABCD);

    // Reset during EXEC drops the command
    run_cmd("pre_r7", 3'd6, 6'd7, 6'd0, 16'h7777);
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = 3'd0; CmdDest = 6'd7; CmdSrcB = 6'd7;
    @(negedge Clock);
    CmdValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_done", Done, 1'b0);
    check("rst_we", RegWriteEnable, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_result", Result, 16'h0000);
    exp_zero = 1'b0; exp_carry = 1'b0; exp_neg = 1'b0;
    check_flags("rst");
    @(negedge Clock);
    check("rst_ready_after", CmdReady, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("rst_no_done", Done, 1'b0);
      @(negedge Clock);
    end
    check("rst_r7", rf[7], 16'h7777);

    // Random commands against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [5:0]  d, s;
      logic [15:0] imm;
      op  = 3'($urandom_range(0, 7));
      d   = 6'($urandom_range(0, 63));
      s   = (n % 5 == 0) ? d : 6'($urandom_range(0, 63));
      imm = 16'($urandom);
      run_cmd("rand", op, d, s, imm);
    end
    for (int r = 0; r < 64; r++) check("final_rf", rf[r], mrf[r]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
